// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the RAM responder state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

  // Byte lanes touched by a transfer; half and word ignore the address
  // LSBs below their natural alignment, sizes above word act as a word.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << lo;
      HSIZE_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahb_ram_array.sv
// Word-organised storage with per-byte write enable, synchronous write and
// combinational read. Contents are not reset.
module ahb_ram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Commit only the enabled byte lanes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM responder with configurable wait states.
// Build option: AHB_RAM_ALIGN_CHK_EN turns misaligned or oversized
// transfers into a two-cycle ERROR response; without it they are masked
// to their natural alignment and HRESP stays OKAY.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | no data phase pending
// ST_WAIT   | data phase stalled, counting down wait states
// ST_ACCESS | final data-phase cycle, write commit / read valid
// ST_ERR1   | first ERROR cycle, HREADYOUT low
// ST_ERR2   | second ERROR cycle, HREADYOUT high
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  slv_state_t            state, state_nxt;
  logic [3:0]            wcnt, wcnt_nxt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            lo_q;
  logic [2:0]            size_q;
  logic                  wr_q;
  logic [31:0]           hrdata_q;
  logic                  fwd_vld;
  logic [ADDR_WIDTH-1:0] fwd_idx;
  logic [3:0]            fwd_strb;
  logic [31:0]           fwd_data;
  logic                  ready_state, accept, bad, commit, rd_done;
  logic [3:0]            strb;
  logic [31:0]           arr_rdata, rd_merged;
  logic                  unused_ok;

  // Upper address bits alias the region; HTRANS[0] does not matter here.
  assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign ready_state = (state == ST_IDLE) || (state == ST_ACCESS) || (state == ST_ERR2);
  assign accept      = HSEL & HREADY & HTRANS[1] & ready_state;

`ifdef AHB_RAM_ALIGN_CHK_EN
  assign bad = (HSIZE > 3'd2) ||
               ((HSIZE == 3'd1) && HADDR[0]) ||
               ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign HRESP = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign bad   = 1'b0;
  assign HRESP = HRESP_OKAY;
`endif

  assign strb      = byte_strobe(size_q, lo_q);
  assign commit    = (state == ST_ACCESS) && wr_q;
  assign rd_done   = (state == ST_ACCESS) && !wr_q;
  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRDATA    = rd_done ? rd_merged : hrdata_q;

  ahb_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (HCLK),
    .we    (commit ? strb : 4'b0000),
    .addr  (idx_q),
    .wdata (HWDATA),
    .rdata (arr_rdata)
  );

  // Per-byte bypass of the last committed write so a following read never
  // depends on the array's write-to-read behaviour.
  always_comb begin
    rd_merged = arr_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_vld && (fwd_idx == idx_q) && fwd_strb[b])
        rd_merged[8*b +: 8] = fwd_data[8*b +: 8];
    end
  end

  // Next-state: ready states take new address phases, WAIT counts down.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      ST_WAIT: begin
        wcnt_nxt = wcnt - 4'd1;
        if (wcnt == 4'd1) state_nxt = ST_ACCESS;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        if (!accept) begin
          state_nxt = ST_IDLE;
        end else if (bad) begin
          state_nxt = ST_ERR1;
        end else if (WS == 4'd0) begin
          state_nxt = ST_ACCESS;
        end else begin
          state_nxt = ST_WAIT;
          wcnt_nxt  = WS;
        end
      end
    endcase
  end

  // State, captured address phase, bypass register and held read data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wcnt     <= 4'd0;
      idx_q    <= '0;
      lo_q     <= 2'b00;
      size_q   <= 3'd0;
      wr_q     <= 1'b0;
      hrdata_q <= 32'd0;
      fwd_vld  <= 1'b0;
      fwd_idx  <= '0;
      fwd_strb <= 4'b0000;
      fwd_data <= 32'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (accept) begin
        idx_q  <= HADDR[ADDR_WIDTH+1:2];
        lo_q   <= HADDR[1:0];
        size_q <= HSIZE;
        wr_q   <= HWRITE;
      end else if (state == ST_ACCESS) begin
        wr_q <= 1'b0;
      end
      fwd_vld <= commit;
      if (commit) begin
        fwd_idx  <= idx_q;
        fwd_strb <= strb;
        fwd_data <= HWDATA;
      end
      if (rd_done) hrdata_q <= rd_merged;
    end
  end

endmodule
